// File: rtl/snn_layer_engine_if.sv
// Bus bundle between the Wishbone/LA glue (master) and the SNN layer engine (slave).
// Carries timestep control, weight-load port, spike result and the debug potential read port.
interface snn_layer_engine_if #(
    parameter int N_IN  = 196,
    parameter int N_OUT = 10,
    parameter int WW    = 8,
    parameter int VW    = 16,
    parameter int AW    = $clog2(N_IN * N_OUT),
    parameter int SW    = $clog2(N_OUT)
);
    logic                 start;
    logic [N_IN-1:0]      in_spikes;
    logic [7:0]           beta;
    logic signed [VW-1:0] v_th;
    logic                 clear_vmem;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic signed [WW-1:0] wr_data;
    logic                 busy;
    logic                 done;
    logic [N_OUT-1:0]     out_spikes;
    logic [SW-1:0]        vmem_sel;
    logic signed [VW-1:0] vmem_data;

    modport master (
        output start, in_spikes, beta, v_th, clear_vmem, wr_en, wr_addr, wr_data, vmem_sel,
        input  busy, done, out_spikes, vmem_data
    );

    modport slave (
        input  start, in_spikes, beta, v_th, clear_vmem, wr_en, wr_addr, wr_data, vmem_sel,
        output busy, done, out_spikes, vmem_data
    );
endinterface

// File: rtl/snn_layer_engine.sv
// Time-stepped leaky integrate-and-fire layer: N_OUT neurons fed by N_IN binary spike lines.
// Each timestep runs LEAK (1 cycle), INTEG (N_IN cycles, one input per cycle, all neurons in
// parallel) and FIRE (1 cycle), then pulses done. Potentials saturate instead of wrapping.
// Optional feature macro SNN_RESET_SUB_EN: when defined a spiking neuron subtracts v_th
// (saturating); when undefined a spiking neuron is reset to zero.
module snn_layer_engine #(
    parameter int N_IN  = 196,
    parameter int N_OUT = 10,
    parameter int WW    = 8,
    parameter int VW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    snn_layer_engine_if.slave bus
);
    localparam int NW = N_IN * N_OUT;
    localparam int AW = $clog2(NW);
    localparam int SW = $clog2(N_OUT);
    localparam int IW = $clog2(N_IN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LEAK  = 2'd1;
    localparam logic [1:0] S_INTEG = 2'd2;
    localparam logic [1:0] S_FIRE  = 2'd3;

    logic [1:0]           r_state;
    logic [IW-1:0]        r_idx;
    logic [N_IN-1:0]      r_spikes;
    logic [7:0]           r_beta;
    logic signed [VW-1:0] r_vth;
    logic signed [WW-1:0] r_weights [NW];
    logic signed [VW-1:0] r_vmem [N_OUT];
    logic [N_OUT-1:0]     r_out;
    logic                 r_done;

    logic signed [VW-1:0] w_vnext [N_OUT];
    logic [N_OUT-1:0]     w_fire;
    logic [AW-1:0]        w_base;
    logic                 w_wrOk;

    // Clamp a one-bit-wider result back into the signed VW range.
    function automatic logic signed [VW-1:0] clampWide(input logic signed [VW:0] x);
        if (x[VW] != x[VW-1])
            return x[VW] ? {1'b1, {(VW-1){1'b0}}} : {1'b0, {(VW-1){1'b1}}};
        return x[VW-1:0];
    endfunction

    // v * beta / 256 with beta unsigned; the arithmetic shift floors toward -inf.
    function automatic logic signed [VW-1:0] leakOf(input logic signed [VW-1:0] v,
                                                     input logic [7:0] b);
        logic signed [VW+8:0] p;
        p = (VW+9)'(v) * (VW+9)'($signed({1'b0, b}));
        return p[VW+7:8];
    endfunction

    assign w_base = AW'(r_idx) * AW'(N_OUT);
    assign w_wrOk = ({1'b0, bus.wr_addr} < (AW+1)'(NW));

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = r_done;
    assign bus.out_spikes = r_out;

    // Debug read of one potential; out-of-range selects read as zero.
    always_comb begin
        bus.vmem_data = '0;
        if (bus.vmem_sel < SW'(N_OUT))
            bus.vmem_data = r_vmem[bus.vmem_sel];
    end

    // Next potential of every neuron for the current phase, plus the fire decisions.
    always_comb begin
        for (int n = 0; n < N_OUT; n++) begin
            w_vnext[n] = r_vmem[n];
            w_fire[n]  = 1'b0;
            case (r_state)
                S_LEAK:  w_vnext[n] = leakOf(r_vmem[n], r_beta);
                S_INTEG: if (r_spikes[r_idx])
                             w_vnext[n] = clampWide((VW+1)'(r_vmem[n]) +
                                                    (VW+1)'(r_weights[w_base + AW'(n)]));
                S_FIRE: begin
                    w_fire[n] = (r_vmem[n] >= r_vth);
                    if (w_fire[n]) begin
`ifdef SNN_RESET_SUB_EN
                        w_vnext[n] = clampWide((VW+1)'(r_vmem[n]) - (VW+1)'(r_vth));
`else
                        w_vnext[n] = '0;
`endif
                    end
                end
                default: w_vnext[n] = r_vmem[n];
            endcase
        end
    end

    // Weight store: written only from IDLE, never cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_IDLE && bus.wr_en && w_wrOk)
            r_weights[bus.wr_addr] <= bus.wr_data;
    end

    // Timestep sequencer, operand latches, potentials and the spike/done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_spikes <= '0;
            r_beta   <= '0;
            r_vth    <= '0;
            r_out    <= '0;
            r_done   <= 1'b0;
            for (int n = 0; n < N_OUT; n++) r_vmem[n] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.clear_vmem)
                        for (int n = 0; n < N_OUT; n++) r_vmem[n] <= '0;
                    if (bus.start) begin
                        r_spikes <= bus.in_spikes;
                        r_beta   <= bus.beta;
                        r_vth    <= bus.v_th;
                        r_state  <= S_LEAK;
                    end
                end
                S_LEAK: begin
                    for (int n = 0; n < N_OUT; n++) r_vmem[n] <= w_vnext[n];
                    r_idx   <= '0;
                    r_state <= S_INTEG;
                end
                S_INTEG: begin
                    for (int n = 0; n < N_OUT; n++) r_vmem[n] <= w_vnext[n];
                    if (r_idx == IW'(N_IN - 1))
                        r_state <= S_FIRE;
                    else
                        r_idx <= r_idx + IW'(1);
                end
                default: begin
                    for (int n = 0; n < N_OUT; n++) r_vmem[n] <= w_vnext[n];
                    r_out   <= w_fire;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
